// File: rtl/macrocell_cfg_loader.sv
// macrocell_cfg_loader
//   Byte-serial configuration loader for one macrocell. A framed stream
//   (SYNC, ADDR, 63 DATA bytes, CHK) is assembled in a shadow register and
//   copied into the active config in a single cycle once the XOR checksum
//   has been verified. Frames for other addresses are fully consumed, so
//   every loader on a shared bus stays aligned with the frame boundaries.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_valid  stream byte and its qualifier
//   in_ready          byte accepted when in_valid && in_ready (low only in COMMIT)
//   abort             synchronous frame abort, highest priority
//   *_mux             active configuration bits (stream bits 0..500 in order)
//   cfg_loaded        sticky: a config has been committed since reset
//   busy              registered "state != IDLE"
//   load_done/err     one-cycle commit result pulses
module macrocell_cfg_loader #(
  parameter logic [7:0] MC_ADDR   = 8'h00,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         abort,
  output logic [0:479] ptgroupbitmap_mux,
  output logic [0:2]   oe_mux,
  output logic [0:1]   gclk_mux,
  output logic         pt1_mux,
  output logic         pt2_mux,
  output logic         pt3_mux,
  output logic         pt4_mux,
  output logic         pt5_mux,
  output logic         gclr_mux,
  output logic         pt4_func_mux,
  output logic         pt5_func_mux,
  output logic         xor_a_mux,
  output logic         xor_b_mux,
  output logic         xor_inv_mux,
  output logic         d_mux,
  output logic         dfast_mux,
  output logic         storage_mux,
  output logic         fb_mux,
  output logic         o_mux,
  output logic         cfg_loaded,
  output logic         busy,
  output logic         load_done,
  output logic         load_err
);

  localparam int NCFG = 501;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_CHK, S_COMMIT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_xfer;
  logic              r_match;
  logic              r_pass;
  logic [7:0]        r_xor;
  logic [5:0]        r_cnt;
  // Indexed by stream bit number; the three padding bits are never stored.
  logic [NCFG-1:0]   r_shadow;
  logic [NCFG-1:0]   r_cfg;
  logic              r_loaded;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  assign in_ready = (r_state != S_COMMIT);
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_xfer && in_data == SYNC_BYTE) w_next = S_ADDR;
        S_ADDR:   if (w_xfer) w_next = S_DATA;
        S_DATA:   if (w_xfer && r_cnt == 6'd62) w_next = S_CHK;
        S_CHK:    if (w_xfer) w_next = S_COMMIT;
        S_COMMIT: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_match  <= 1'b0;
      r_pass   <= 1'b0;
      r_xor    <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_cfg    <= '0;
      r_loaded <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (!abort && w_xfer) begin
        case (r_state)
          S_ADDR: begin
            r_match <= (in_data == MC_ADDR);
            r_xor   <= in_data;
            r_cnt   <= '0;
          end
          S_DATA: begin
            // Last data byte holds only 5 config bits; bits 7:5 are padding.
            if (r_match) begin
              if (r_cnt == 6'd62) r_shadow[500:496] <= in_data[4:0];
              else                r_shadow[{r_cnt, 3'b000} +: 8] <= in_data;
            end
            r_xor <= r_xor ^ in_data;
            r_cnt <= r_cnt + 6'd1;
          end
          S_CHK:   r_pass <= (r_xor == in_data);
          default: ;
        endcase
      end
      if (!abort && r_state == S_COMMIT && r_match) begin
        if (r_pass) begin
          r_cfg    <= r_shadow;
          r_loaded <= 1'b1;
          r_done   <= 1'b1;
        end else begin
          r_err    <= 1'b1;
        end
      end
    end
  end

  // Output fields are declared ascending, so element i is stream bit base+i.
  for (genvar i = 0; i < 480; i++) begin : g_ptg
    assign ptgroupbitmap_mux[i] = r_cfg[i];
  end
  for (genvar i = 0; i < 3; i++) begin : g_oe
    assign oe_mux[i] = r_cfg[480+i];
  end
  for (genvar i = 0; i < 2; i++) begin : g_gclk
    assign gclk_mux[i] = r_cfg[483+i];
  end

  assign pt1_mux      = r_cfg[485];
  assign pt2_mux      = r_cfg[486];
  assign pt3_mux      = r_cfg[487];
  assign pt4_mux      = r_cfg[488];
  assign pt5_mux      = r_cfg[489];
  assign gclr_mux     = r_cfg[490];
  assign pt4_func_mux = r_cfg[491];
  assign pt5_func_mux = r_cfg[492];
  assign xor_a_mux    = r_cfg[493];
  assign xor_b_mux    = r_cfg[494];
  assign xor_inv_mux  = r_cfg[495];
  assign d_mux        = r_cfg[496];
  assign dfast_mux    = r_cfg[497];
  assign storage_mux  = r_cfg[498];
  assign fb_mux       = r_cfg[499];
  assign o_mux        = r_cfg[500];

  assign cfg_loaded = r_loaded;
  assign busy       = r_busy;
  assign load_done  = r_done;
  assign load_err   = r_err;

endmodule

// File: tb/tb_macrocell_cfg_loader.sv
module tb_macrocell_cfg_loader;

  localparam logic [7:0] MCA  = 8'h03;
  localparam logic [7:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0;
  logic abort = 1'b0;
  logic in_ready;
  logic [0:479] ptg;
  logic [0:2] oe;
  logic [0:1] gck;
  logic pt1, pt2, pt3, pt4, pt5, gclr, pt4f, pt5f, xa, xb, xi, dm, dfm, stm, fbm, om;
  logic cfg_loaded, busy, load_done, load_err;

  always #5 clk = ~clk;

  macrocell_cfg_loader #(.MC_ADDR(MCA), .SYNC_BYTE(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort),
    .ptgroupbitmap_mux(ptg), .oe_mux(oe), .gclk_mux(gck),
    .pt1_mux(pt1), .pt2_mux(pt2), .pt3_mux(pt3), .pt4_mux(pt4), .pt5_mux(pt5),
    .gclr_mux(gclr), .pt4_func_mux(pt4f), .pt5_func_mux(pt5f),
    .xor_a_mux(xa), .xor_b_mux(xb), .xor_inv_mux(xi), .d_mux(dm),
    .dfast_mux(dfm), .storage_mux(stm), .fb_mux(fbm), .o_mux(om),
    .cfg_loaded(cfg_loaded), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  // Concatenation in stream order: stream bit k sits at position 500-k.
  logic [500:0] dut_cat;
  assign dut_cat = {ptg, oe, gck, pt1, pt2, pt3, pt4, pt5, gclr, pt4f, pt5f,
                    xa, xb, xi, dm, dfm, stm, fbm, om};

  int checks = 0;
  int failures = 0;
  bit chk_on = 1'b0;
  bit gaps = 1'b0;

  task automatic chk(input string nm, input logic [500:0] act, input logic [500:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // m_pos counts bytes of the current frame seen so far (0: hunting SYNC,
  // 66: whole frame received, commit cycle).
  int           m_pos = 0;
  logic [7:0]   m_fr [0:64];
  logic [500:0] m_cat = '0;
  bit           m_loaded = 0, m_done = 0, m_err = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_cat = '0; m_loaded = 0; m_done = 0; m_err = 0;
    end else begin
      m_done = 0; m_err = 0;
      if (abort) begin
        m_pos = 0;
      end else if (m_pos == 66) begin
        if (m_fr[0] == MCA) begin
          logic [7:0] x;
          x = 8'h00;
          for (int i = 0; i < 64; i++) x ^= m_fr[i];
          if (x == m_fr[64]) begin
            for (int k = 0; k < 501; k++) m_cat[500-k] = m_fr[1 + k/8][k%8];
            m_loaded = 1; m_done = 1;
          end else begin
            m_err = 1;
          end
        end
        m_pos = 0;
      end else if (in_valid) begin
        if (m_pos == 0) begin
          if (in_data == SYNC) m_pos = 1;
        end else begin
          m_fr[m_pos-1] = in_data;
          m_pos++;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cfg", dut_cat, m_cat);
      chk("cfg_loaded", 501'(cfg_loaded), 501'(m_loaded));
      chk("load_done", 501'(load_done), 501'(m_done));
      chk("load_err", 501'(load_err), 501'(m_err));
      chk("in_ready", 501'(in_ready), 501'(m_pos != 66));
      chk("busy", 501'(busy), 501'(m_pos != 0));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] fd [0:62];

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send(input logic [7:0] b);
    if (gaps) while ($urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(negedge clk); end
    in_data = b; in_valid = 1'b1;
    for (int g = 0; g < 16; g++) begin
      bit r;
      r = in_ready;
      @(negedge clk);
      if (r) begin in_valid = 1'b0; return; end
    end
    in_valid = 1'b0;
    failures++;
    $display("FAIL send_timeout act=stalled exp=accepted t=%0t", $time);
  endtask

  task automatic do_abort();
    in_valid = 1'b1; in_data = 8'($urandom); abort = 1'b1;
    @(negedge clk);
    abort = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] flip, input int abort_at);
    logic [7:0] x;
    x = addr;
    for (int i = 0; i < 63; i++) x ^= fd[i];
    send(SYNC);
    send(addr);
    for (int i = 0; i < 63; i++) begin
      send(fd[i]);
      if (i == abort_at) begin do_abort(); return; end
    end
    send(x ^ flip);
  endtask

  task automatic rand_fd();
    for (int i = 0; i < 63; i++) fd[i] = 8'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cfg_zero", dut_cat, '0);
    chk("rst_busy", 501'(busy), 501'(0));
    chk("rst_loaded", 501'(cfg_loaded), 501'(0));
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    chk("idle_ready", 501'(in_ready), 501'(1));

    // All-ones frame
    for (int i = 0; i < 63; i++) fd[i] = 8'hFF;
    fd[62] = 8'h1F;
    send_frame(MCA, 8'h00, -1);
    chk("commit_cycle_ready", 501'(in_ready), 501'(0));
    chk("commit_cycle_nodone", 501'(load_done), 501'(0));
    @(negedge clk);
    chk("ones_done", 501'(load_done), 501'(1));
    chk("ones_cfg", dut_cat, {501{1'b1}});
    chk("ones_model_pin", m_cat, {501{1'b1}});
    chk("ones_loaded", 501'(cfg_loaded), 501'(1));
    @(negedge clk);
    chk("ones_done_1cyc", 501'(load_done), 501'(0));

    // Same frame, corrupted checksum
    send_frame(MCA, 8'h01, -1);
    @(negedge clk);
    chk("bad_err", 501'(load_err), 501'(1));
    chk("bad_cfg_kept", dut_cat, {501{1'b1}});
    @(negedge clk);
    chk("bad_err_1cyc", 501'(load_err), 501'(0));

    // Frame for another loader, then a good one for this loader
    rand_fd();
    send_frame(8'h04, 8'h00, -1);
    @(negedge clk);
    chk("other_nodone", 501'(load_done | load_err), 501'(0));
    chk("other_cfg_kept", dut_cat, {501{1'b1}});
    rand_fd();
    send_frame(MCA, 8'h00, -1);
    @(negedge clk);
    chk("after_other_done", 501'(load_done), 501'(1));

    // Abort mid-frame, then single-bit frame
    rand_fd();
    send_frame(MCA, 8'h00, 20);
    for (int i = 0; i < 63; i++) fd[i] = 8'h00;
    fd[0] = 8'h01;
    send_frame(MCA, 8'h00, -1);
    @(negedge clk);
    chk("bit0_done", 501'(load_done), 501'(1));
    chk("bit0_cfg", dut_cat, {1'b1, 500'b0});
    chk("bit0_ptg0", 501'(ptg[0]), 501'(1));
    @(negedge clk);
    chk("bit0_done_1cyc", 501'(load_done), 501'(0));

    // Gappy stream with garbage before SYNC
    gaps = 1'b1;
    send(8'h00); send(8'h5A);
    rand_fd();
    send_frame(MCA, 8'h00, -1);
    @(negedge clk);
    chk("gappy_done", 501'(load_done), 501'(1));
    gaps = 1'b0;

    // Randomized frames
    for (int n = 0; n < 25; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : MCA;
      gaps = bit'($urandom_range(0, 1));
      rand_fd();
      if ($urandom_range(0, 4) == 0) send(8'($urandom));
      send_frame(a, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                 ($urandom_range(0, 5) == 0) ? $urandom_range(0, 62) : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    gaps = 1'b0;

    // Reset in the middle of DATA after a known-good commit
    for (int i = 0; i < 63; i++) fd[i] = 8'hFF;
    fd[62] = 8'h1F;
    send_frame(MCA, 8'h00, -1);
    repeat (2) @(negedge clk);
    send(SYNC); send(MCA);
    for (int i = 0; i < 10; i++) send(8'($urandom));
    chk("pre_rst_busy", 501'(busy), 501'(1));
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_cfg", dut_cat, '0);
    chk("midrst_loaded", 501'(cfg_loaded), 501'(0));
    chk("midrst_busy", 501'(busy), 501'(0));
    chk("midrst_ready", 501'(in_ready), 501'(1));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
